// File: rtl/mem_arbiter.sv
// Memory bus arbiter for the pcpu core: shares one external bus between instruction fetch and the data port.
// Optional bus watchdog compiled in with `define MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic              d_read_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_busy,
    output logic              mem_ready,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_ack,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_req,
    output logic              bus_we,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    input  logic              err_clr,
    output logic              bus_err,
    output logic [2:0]        dbg_state
);

    // Handshakes: a data or fetch request is accepted only at an edge where the
    // arbiter is IDLE; mem_busy=1 tells the core to retry. A bus cycle is
    // bus_req=1 held with stable address/data until bus_ack is sampled high.

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DREAD  = 3'd2,
        DWRITE = 3'd3,
        DHOLD  = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   accept;
    logic   abort;
    logic   complete;
    logic [DATA_W-1:0] rd_word;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] wd_cnt;
    logic             err_q;

    // Abort fires on the TIMEOUT-th bus_req cycle that sees no acknowledge.
    assign abort = bus_req && !bus_ack && (wd_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (accept) begin
            wd_cnt <= '0;
        end else if (bus_req && !bus_ack && !abort) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (abort) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign bus_err = err_q;
`else
    logic unused_cfg;

    assign abort      = 1'b0;
    assign bus_err    = 1'b0;
    assign unused_cfg = err_clr ^ (TIMEOUT > 0);
`endif

    assign complete = bus_ack || abort;
    assign rd_word  = abort ? {DATA_W{1'b1}} : bus_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                // A simultaneous read and write keeps the write and drops the read.
                if (d_write) begin
                    state_d = DWRITE;
                    accept  = 1'b1;
                end else if (d_read) begin
                    state_d = DREAD;
                    accept  = 1'b1;
                end else if (f_req) begin
                    state_d = FETCH;
                    accept  = 1'b1;
                end
            end
            FETCH:   if (complete) state_d = IDLE;
            DREAD:   if (complete) state_d = DHOLD;
            DWRITE:  if (complete) state_d = IDLE;
            DHOLD:   if (d_read_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus strobes decode state only, so reset drops bus_req asynchronously.
    assign bus_req   = (state_q == FETCH) || (state_q == DREAD) || (state_q == DWRITE);
    assign bus_we    = (state_q == DWRITE);
    assign mem_busy  = bus_req;
    assign mem_ready = (state_q == DHOLD);
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_addr  <= '0;
            bus_wdata <= '0;
            d_rdata   <= '0;
            f_rdata   <= '0;
            f_ack     <= 1'b0;
        end else begin
            f_ack <= 1'b0;
            if (accept) begin
                bus_addr <= (d_write || d_read) ? d_addr : f_addr;
                if (d_write) begin
                    bus_wdata <= d_wdata;
                end
            end
            if (state_q == FETCH && complete) begin
                f_rdata <= rd_word;
                f_ack   <= 1'b1;
            end
            if (state_q == DREAD && complete) begin
                d_rdata <= rd_word;
            end
        end
    end

endmodule
